// File: rtl/alu_shift_arbiter_rv32i.sv
// Two-requester arbiter in front of one shared RV32I shift unit (SLL/SRL/SRA).
// Define ALU_SHIFT_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_shift_arbiter_rv32i (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_type,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_type,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        owner_reg;
    logic [31:0] rsp_data_reg;

    logic [1:0]  req_valid;
    logic [1:0]  grant;
    logic [1:0]  rsp_ready_vec;
    logic        prefer1;
    logic        owner_rsp_ready;
    logic        can_accept;
    logic        accept;
    logic        rsp_handshake;
    logic [31:0] sel_in;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_type;
    logic [31:0] shift_result;

`ifdef ALU_SHIFT_ARB_RR_EN
    logic last_grant_reg;

    // Ties go to whichever requester did not win the previous acceptance.
    assign prefer1 = ~last_grant_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= grant[1];
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    assign req_valid     = {req1_valid, req0_valid};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    assign grant[1] = req_valid[1] & (~req_valid[0] | prefer1);
    assign grant[0] = req_valid[0] & ~grant[1];

    // The held result frees the datapath in the same cycle its owner takes it.
    assign owner_rsp_ready = rsp_ready_vec[owner_reg];
    assign rsp_handshake   = (state_reg == RESP) & owner_rsp_ready;
    assign can_accept      = ~rst & ((state_reg == IDLE) | owner_rsp_ready);
    assign accept          = can_accept & (req_valid[0] | req_valid[1]);

    assign sel_in    = grant[1] ? req1_in    : req0_in;
    assign sel_shamt = grant[1] ? req1_shamt : req0_shamt;
    assign sel_type  = grant[1] ? req1_type  : req0_type;

    always_comb begin
        shift_result = 32'd0;
        case (sel_type)
            2'b00:   shift_result = sel_in << sel_shamt;
            2'b01:   shift_result = sel_in >> sel_shamt;
            2'b10:   shift_result = 32'($signed(sel_in) >>> sel_shamt);
            default: shift_result = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    state_next = RESP;
                end else if (rsp_handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = can_accept & grant[0];
        req1_ready = can_accept & grant[1];
        rsp0_valid = (state_reg == RESP) & ~owner_reg;
        rsp1_valid = (state_reg == RESP) & owner_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_reg <= 32'd0;
            owner_reg    <= 1'b0;
        end else if (accept) begin
            rsp_data_reg <= shift_result;
            owner_reg    <= grant[1];
        end
    end

    assign rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_alu_shift_arbiter_rv32i.sv
// Self-checking bench for alu_shift_arbiter_rv32i: directed vector table, tie, backpressure,
// reset and randomized traffic, all compared against a cycle-level reference model.
module tb_alu_shift_arbiter_rv32i;

    logic        clk = 1'b0;
    logic        rst;
    logic        v   [2];
    logic [31:0] din [2];
    logic [4:0]  sh  [2];
    logic [1:0]  ty  [2];
    logic        rr  [2];
    logic        rdy0, rdy1, rsv0, rsv1;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_busy;
    int          m_owner;
    logic [31:0] m_data;
    int          m_last;

    // values observed at the last run_cycle sample point
    logic        obs_r0, obs_r1, obs_v0, obs_v1;
    logic [31:0] obs_data;

`ifdef ALU_SHIFT_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_shift_arbiter_rv32i dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_ready (rdy0),
        .req0_in    (din[0]),
        .req0_shamt (sh[0]),
        .req0_type  (ty[0]),
        .req1_valid (v[1]),
        .req1_ready (rdy1),
        .req1_in    (din[1]),
        .req1_shamt (sh[1]),
        .req1_type  (ty[1]),
        .rsp0_valid (rsv0),
        .rsp0_ready (rr[0]),
        .rsp1_valid (rsv1),
        .rsp1_ready (rr[1]),
        .rsp_data   (rdata)
    );

    typedef struct {
        int          req;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] expect_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] shift_ref(input logic [31:0] x, input int s, input logic [1:0] t);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        case (t)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return x[31] ? ((x >> s) | ~(ones >> s)) : (x >> s);
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            v[n]   = 1'b0;
            din[n] = 32'd0;
            sh[n]  = 5'd0;
            ty[n]  = 2'd0;
            rr[n]  = 1'b0;
        end
    endtask

    // One clock: compare DUT against the model just before the edge, then advance both.
    task automatic run_cycle();
        logic any, ok_acc;
        int   win;
        logic [31:0] res;
        #2;
        any = v[0] | v[1];
        if (v[0] && v[1]) win = (RR_MODE && m_last == 0) ? 1 : 0;
        else              win = v[1] ? 1 : 0;
        ok_acc = !rst && (!m_busy || rr[m_owner]);
        obs_r0 = rdy0; obs_r1 = rdy1; obs_v0 = rsv0; obs_v1 = rsv1; obs_data = rdata;
        chk("req0_ready", {31'd0, rdy0}, {31'd0, ok_acc && any && win == 0});
        chk("req1_ready", {31'd0, rdy1}, {31'd0, ok_acc && any && win == 1});
        chk("rsp0_valid", {31'd0, rsv0}, {31'd0, m_busy && m_owner == 0});
        chk("rsp1_valid", {31'd0, rsv1}, {31'd0, m_busy && m_owner == 1});
        chk("rsp_data", rdata, m_data);
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_data = 32'd0;
            m_last = 1;
        end else if (ok_acc && any) begin
            res = shift_ref(din[win], int'(sh[win]), ty[win]);
            $display("accept req%0d in=%h shamt=%0d type=%0d -> %h", win, din[win], sh[win], ty[win], res);
            m_data  = res;
            m_owner = win;
            m_busy  = 1'b1;
            m_last  = win;
        end else if (m_busy && rr[m_owner]) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int tie_owner [4];
        logic [31:0] held;

        vecs[0] = '{0, 32'h8000_0001, 5'd1,  2'b10, 32'hC000_0000};
        vecs[1] = '{1, 32'h0000_F00F, 5'd4,  2'b00, 32'h000F_00F0};
        vecs[2] = '{1, 32'h0000_F00F, 5'd4,  2'b01, 32'h0000_0F00};
        vecs[3] = '{1, 32'h0000_F00F, 5'd4,  2'b11, 32'h0000_0000};
        vecs[4] = '{0, 32'hFFFF_FFFF, 5'd0,  2'b01, 32'hFFFF_FFFF};
        vecs[5] = '{0, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001};

        m_busy = 1'b0; m_owner = 0; m_data = 32'd0; m_last = 1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // reset state, readies held low while rst is high even with a request present
        v[0] = 1'b1;
        run_cycle();
        chk("reset_req0_ready", {31'd0, obs_r0}, 32'd0);
        chk("reset_rsp_data", obs_data, 32'd0);
        rst = 1'b0;
        idle_inputs();

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            v[vecs[i].req]   = 1'b1;
            din[vecs[i].req] = vecs[i].operand;
            sh[vecs[i].req]  = vecs[i].shamt;
            ty[vecs[i].req]  = vecs[i].op;
            run_cycle();
            chk("vec_accept", {31'd0, (vecs[i].req == 0) ? obs_r0 : obs_r1}, 32'd1);
            idle_inputs();
            rr[vecs[i].req] = 1'b1;
            run_cycle();
            chk("vec_rsp_valid", {31'd0, (vecs[i].req == 0) ? obs_v0 : obs_v1}, 32'd1);
            chk("vec_rsp_data", obs_data, vecs[i].expect_data);
        end

        // ties right after reset, responses always taken
        for (int k = 0; k < 4; k++) tie_owner[k] = RR_MODE ? (k % 2) : 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 2; n++) begin
                v[n] = 1'b1; din[n] = $urandom; sh[n] = 5'($urandom); ty[n] = 2'($urandom);
                rr[n] = 1'b1;
            end
            run_cycle();
            chk("tie_owner0", {31'd0, obs_r0}, {31'd0, tie_owner[k] == 0});
            chk("tie_owner1", {31'd0, obs_r1}, {31'd0, tie_owner[k] == 1});
        end
        idle_inputs();
        rr[0] = 1'b1; rr[1] = 1'b1;
        run_cycle();

        // backpressure on rsp0, then handshake and req1 acceptance in the same cycle
        do_reset();
        v[0] = 1'b1; din[0] = 32'h1234_5678; sh[0] = 5'd8; ty[0] = 2'b00;
        held = 32'h3456_7800;
        run_cycle();
        v[0] = 1'b0;
        v[1] = 1'b1; din[1] = 32'h8765_4321; sh[1] = 5'd4; ty[1] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            chk("bp_req0_ready", {31'd0, obs_r0}, 32'd0);
            chk("bp_req1_ready", {31'd0, obs_r1}, 32'd0);
            chk("bp_rsp0_valid", {31'd0, obs_v0}, 32'd1);
            chk("bp_rsp_data", obs_data, held);
        end
        rr[0] = 1'b1;
        run_cycle();
        chk("bp_overlap_req1_ready", {31'd0, obs_r1}, 32'd1);
        idle_inputs();
        run_cycle();
        chk("bp_rsp1_valid", {31'd0, obs_v1}, 32'd1);
        chk("bp_rsp0_cleared", {31'd0, obs_v0}, 32'd0);
        chk("bp_rsp1_data", obs_data, 32'hF876_5432);
        rr[1] = 1'b1;
        run_cycle();

        // reset while a result is held
        idle_inputs();
        v[0] = 1'b1; din[0] = 32'hDEAD_BEEF; sh[0] = 5'd3; ty[0] = 2'b01;
        run_cycle();
        rst = 1'b1;
        run_cycle();
        chk("rst_mid_req0_ready", {31'd0, obs_r0}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        rr[0] = 1'b1; rr[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            chk("rst_mid_rsp0_valid", {31'd0, obs_v0}, 32'd0);
            chk("rst_mid_rsp_data", obs_data, 32'd0);
        end

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                v[n]   = ($urandom_range(0, 99) < 60);
                din[n] = $urandom;
                sh[n]  = 5'($urandom);
                ty[n]  = 2'($urandom);
                rr[n]  = ($urandom_range(0, 99) < 70);
            end
            rst = ($urandom_range(0, 99) < 2);
            run_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        rr[0] = 1'b1; rr[1] = 1'b1;
        run_cycle();
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
